// File: rtl/kmc_misc_gen.sv
// kmc_misc_gen: KMC11-class miscellaneous control/status register.
// Latency: register fields update one clk after i_ld; irq pulse is combinational;
//   timer expiry pulses one clk after the tick edge at which a count leaves 1.
// Backpressure: none; i_ld is a plain write strobe and is always accepted.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   i_init         soft init, identical in effect to rst
//   i_ld           register write strobe
//   i_wdata        write data from the microsequencer ALU
//   i_irqi         interrupt-out state, shown on the readback MSB
//   i_set_sticky   hardware set of sticky error bits
//   o_irq_set      IRQ trigger pulse (i_ld & i_wdata MSB)
//   o_tmr_expire   one-clk expiry pulse per timer
//   o_ctl          plain R/W control bits, LSB-aligned
//   o_rdata        register readback
//
// Register layout, MSB to LSB:
//   [WIDTH-1]                    IRQ (write: trigger pulse, read: i_irqi)
//   [WIDTH-2 : WIDTH-1-NTMR]     timers, timer i at bit WIDTH-1-NTMR+i
//                                (write 1: start/retrigger, read 1: idle)
//   [WIDTH-2-NTMR : NSTKY]       plain control bits
//   [NSTKY-1 : 0]                sticky error bits

module kmc_misc_gen #(
  parameter int              WIDTH        = 8,
  parameter int              NTMR         = 2,
  parameter int              CNTW         = 12,
  parameter int              TMRVAL       = 3000,
  parameter int              PRESCALE     = 1,
  parameter logic [NTMR-1:0] TMR_PERIODIC = '0,
  parameter int              NSTKY        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_init,
  input  logic                          i_ld,
  input  logic [WIDTH-1:0]              i_wdata,
  input  logic                          i_irqi,
  input  logic [NSTKY-1:0]              i_set_sticky,
  output logic                          o_irq_set,
  output logic [NTMR-1:0]               o_tmr_expire,
  output logic [WIDTH-NTMR-NSTKY-2:0]   o_ctl,
  output logic [WIDTH-1:0]              o_rdata
);

  localparam int NCTL    = WIDTH - NTMR - NSTKY - 1;
  localparam int TMR_LSB = WIDTH - 1 - NTMR;
  localparam int CTL_LSB = NSTKY;

  // Prescaler counter width; a single bit is kept even when PRESCALE=1 so the
  // logic stays uniform (the counter then simply sits at zero).
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [CNTW-1:0] RELOAD  = CNTW'(TMRVAL);
  localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

  logic              w_clr;
  logic              w_tick;
  logic [PW-1:0]     r_pre;
  logic [NCTL-1:0]   r_ctl;
  logic [NSTKY-1:0]  r_sticky;
  logic [NTMR-1:0]   w_tmr_idle;

  // Soft init and reset are indistinguishable to the register state.
  assign w_clr = rst | i_init;

  //--------------------------------------------------------------------------
  // Prescaler: free-running; timer writes never disturb its phase, which is
  // why expiry latency varies by up to one tick when PRESCALE > 1.
  //--------------------------------------------------------------------------
  assign w_tick = (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (w_clr || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  //--------------------------------------------------------------------------
  // IRQ trigger: pure write decode, nothing stored.
  //--------------------------------------------------------------------------
  assign o_irq_set = i_ld & i_wdata[WIDTH-1];

  //--------------------------------------------------------------------------
  // Plain control bits.
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_ctl <= '0;
    end else if (i_ld) begin
      r_ctl <= i_wdata[CTL_LSB +: NCTL];
    end
  end

  assign o_ctl = r_ctl;

  //--------------------------------------------------------------------------
  // Sticky error bits: a hardware set beats a software write in the same
  // cycle so an error can never be lost by a coincident clear.
  //--------------------------------------------------------------------------
  for (genvar gs = 0; gs < NSTKY; gs++) begin : g_stky
    always_ff @(posedge clk) begin
      if (w_clr) begin
        r_sticky[gs] <= 1'b0;
      end else if (i_set_sticky[gs]) begin
        r_sticky[gs] <= 1'b1;
      end else if (i_ld) begin
        r_sticky[gs] <= i_wdata[gs];
      end
    end
  end

  //--------------------------------------------------------------------------
  // Timers. Each counts down in prescaled ticks; the expiry pulse is
  // registered and fires on the tick that takes the count out of 1.
  //--------------------------------------------------------------------------
  for (genvar gi = 0; gi < NTMR; gi++) begin : g_tmr
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            r_exp;
    logic            w_exp_nxt;
    logic            w_wbit;

    assign w_wbit = i_wdata[TMR_LSB + gi];

    if (TMR_PERIODIC[gi]) begin : g_per
      // Periodic: writing 1 starts the timer, writing 0 stops it silently.
      logic r_run;
      logic w_run_nxt;

      always_comb begin
        w_run_nxt = r_run;
        w_cnt_nxt = r_cnt;
        w_exp_nxt = 1'b0;
        if (i_ld) begin
          if (w_wbit) begin
            w_run_nxt = 1'b1;
            w_cnt_nxt = RELOAD;
          end else begin
            w_run_nxt = 1'b0;
            w_cnt_nxt = '0;
          end
        end else if (w_tick && r_run && (r_cnt != '0)) begin
          if (r_cnt == CNT_ONE) begin
            // Reload instead of passing through 0, so the idle bit stays
            // low for as long as the timer runs.
            w_cnt_nxt = RELOAD;
            w_exp_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (w_clr) begin
          r_run <= 1'b0;
        end else begin
          r_run <= w_run_nxt;
        end
      end
    end else begin : g_one
      // One-shot: writing 1 (re)triggers; writing 0 leaves the timer alone.
      always_comb begin
        w_cnt_nxt = r_cnt;
        w_exp_nxt = 1'b0;
        if (i_ld && w_wbit) begin
          w_cnt_nxt = RELOAD;
        end else if (w_tick && (r_cnt != '0)) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          w_exp_nxt = (r_cnt == CNT_ONE);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_clr) begin
        r_cnt <= '0;
        r_exp <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_exp <= w_exp_nxt;
      end
    end

    assign w_tmr_idle[gi]   = (r_cnt == '0);
    assign o_tmr_expire[gi] = r_exp;
  end

  //--------------------------------------------------------------------------
  // Readback.
  //--------------------------------------------------------------------------
  assign o_rdata = {i_irqi, w_tmr_idle, r_ctl, r_sticky};

endmodule

// File: tb/tb_kmc_misc_gen.sv
// tb_kmc_misc_gen: scoreboard bench for kmc_misc_gen.
// Stimulus pushes per-cycle expectations; a negedge monitor checks them.
// No backpressure; the bench is cycle-driven.

module tb_kmc_misc_gen;

  localparam int SEL_RD  = 0;
  localparam int SEL_CTL = 1;
  localparam int SEL_IRQ = 2;
  localparam int SEL_EXP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_init;
  logic       i_ld;
  logic [7:0] i_wdata;
  logic       i_irqi;
  logic [0:0] i_set_sticky;
  logic       o_irq_set;
  logic [1:0] o_tmr_expire;
  logic [3:0] o_ctl;
  logic [7:0] o_rdata;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    int         sel;
    logic [7:0] mask;
    logic [7:0] val;
    string      name;
  } exp_t;

  exp_t sb[$];

  kmc_misc_gen #(
    .WIDTH(8), .NTMR(2), .CNTW(12), .TMRVAL(5), .PRESCALE(1),
    .TMR_PERIODIC(2'b10), .NSTKY(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_init       (i_init),
    .i_ld         (i_ld),
    .i_wdata      (i_wdata),
    .i_irqi       (i_irqi),
    .i_set_sticky (i_set_sticky),
    .o_irq_set    (o_irq_set),
    .o_tmr_expire (o_tmr_expire),
    .o_ctl        (o_ctl),
    .o_rdata      (o_rdata)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen; outputs observed at the following negedge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(input int at, input int sel, input logic [7:0] mask,
                                   input logic [7:0] val, input string name);
    exp_t e;
    e.at = at; e.sel = sel; e.mask = mask; e.val = val; e.name = name;
    sb.push_back(e);
  endfunction

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    logic [7:0] act;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        case (sb[i].sel)
          SEL_RD:  act = o_rdata;
          SEL_CTL: act = {4'b0, o_ctl};
          SEL_IRQ: act = {7'b0, o_irq_set};
          default: act = {6'b0, o_tmr_expire};
        endcase
        act = act & sb[i].mask;
        checks++;
        if (act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%02h want=%02h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t;
    rst = 1'b1; i_init = 1'b0; i_ld = 1'b0; i_wdata = 8'h00;
    i_irqi = 1'b0; i_set_sticky = 1'b0;

    // 1: reset state
    step(); step();
    t = cyc;
    push_exp(t, SEL_RD,  8'hFF, 8'h60, "rst_rdata");
    push_exp(t, SEL_CTL, 8'hFF, 8'h00, "rst_ctl");
    push_exp(t, SEL_IRQ, 8'hFF, 8'h00, "rst_irq");
    push_exp(t, SEL_EXP, 8'hFF, 8'h00, "rst_expire");
    rst = 1'b0;
    step();

    // 2: plain bits, irq pulse, irqi readback
    t = cyc; i_ld = 1'b1; i_wdata = 8'h1E;
    push_exp(t, SEL_IRQ, 8'hFF, 8'h00, "irq_1e");
    step(); t = cyc;
    push_exp(t, SEL_RD,  8'hFF, 8'h7E, "rd_1e");
    push_exp(t, SEL_CTL, 8'hFF, 8'h0F, "ctl_1e");
    i_wdata = 8'h80;
    push_exp(t, SEL_IRQ, 8'hFF, 8'h01, "irq_80");
    step(); t = cyc; i_ld = 1'b0;
    push_exp(t, SEL_IRQ, 8'hFF, 8'h00, "irq_80_off");
    push_exp(t, SEL_CTL, 8'hFF, 8'h00, "ctl_80");
    push_exp(t, SEL_RD,  8'hFF, 8'h60, "rd_80");
    step(); t = cyc; i_irqi = 1'b1;
    push_exp(t, SEL_RD,  8'hFF, 8'hE0, "rd_irqi");
    step(); i_irqi = 1'b0;
    step();

    // 3a: one-shot timer0, expires 5 edges after load
    t = cyc; i_ld = 1'b1; i_wdata = 8'h20;
    for (int k = 0; k < 5; k++) begin
      push_exp(t + 1 + k, SEL_RD,  8'h20, 8'h00, "t0_busy");
      push_exp(t + 1 + k, SEL_EXP, 8'hFF, 8'h00, "t0_nopulse");
    end
    push_exp(t + 6, SEL_RD,  8'h20, 8'h20, "t0_idle");
    push_exp(t + 6, SEL_EXP, 8'hFF, 8'h01, "t0_pulse");
    push_exp(t + 7, SEL_EXP, 8'hFF, 8'h00, "t0_pulse_end");
    step(); i_ld = 1'b0;
    repeat (9) step();

    // 3b: retrigger at cycle 3 moves expiry to cycle 8
    t = cyc; i_ld = 1'b1; i_wdata = 8'h20;
    for (int k = 0; k < 8; k++) begin
      push_exp(t + 1 + k, SEL_RD,  8'h20, 8'h00, "t0r_busy");
      push_exp(t + 1 + k, SEL_EXP, 8'hFF, 8'h00, "t0r_nopulse");
    end
    push_exp(t + 9,  SEL_RD,  8'h20, 8'h20, "t0r_idle");
    push_exp(t + 9,  SEL_EXP, 8'hFF, 8'h01, "t0r_pulse");
    push_exp(t + 10, SEL_EXP, 8'hFF, 8'h00, "t0r_pulse_end");
    step(); i_ld = 1'b0;
    step(); step();
    i_ld = 1'b1; i_wdata = 8'h20;
    step(); i_ld = 1'b0;
    repeat (9) step();

    // 4: periodic timer1 pulses every 5 edges, then stop
    t = cyc; i_ld = 1'b1; i_wdata = 8'h40;
    for (int k = 0; k < 17; k++) begin
      push_exp(t + 1 + k, SEL_RD,  8'h40, 8'h00, "t1_busy");
      push_exp(t + 1 + k, SEL_EXP, 8'hFF,
               (k == 5 || k == 10 || k == 15) ? 8'h02 : 8'h00, "t1_pulse");
    end
    for (int k = 17; k < 27; k++) begin
      push_exp(t + 1 + k, SEL_RD,  8'h40, 8'h40, "t1_stopped");
      push_exp(t + 1 + k, SEL_EXP, 8'hFF, 8'h00, "t1_nopulse");
    end
    step(); i_ld = 1'b0;
    repeat (16) step();
    i_ld = 1'b1; i_wdata = 8'h00;
    step(); i_ld = 1'b0;
    repeat (11) step();

    // 5: sticky set beats a same-cycle write of 0, holds, then clears
    t = cyc; i_ld = 1'b1; i_wdata = 8'h00; i_set_sticky = 1'b1;
    push_exp(t + 1, SEL_RD, 8'h01, 8'h01, "stky_set");
    push_exp(t + 2, SEL_RD, 8'h01, 8'h01, "stky_hold");
    push_exp(t + 3, SEL_RD, 8'h01, 8'h00, "stky_clr");
    step(); i_ld = 1'b0; i_set_sticky = 1'b0;
    step(); i_ld = 1'b1; i_wdata = 8'h00;
    step(); i_ld = 1'b0;
    step();

    // 6: init mid-count overrides a coincident write and sticky set
    t = cyc; i_ld = 1'b1; i_wdata = 8'h60;
    push_exp(t + 3, SEL_RD, 8'hFF, 8'h00, "pre_init_rd");
    for (int k = 4; k < 25; k++) begin
      push_exp(t + k, SEL_RD,  8'hFF, 8'h60, "init_rd");
      push_exp(t + k, SEL_EXP, 8'hFF, 8'h00, "init_nopulse");
    end
    step(); i_ld = 1'b0;
    step(); step();
    i_init = 1'b1; i_ld = 1'b1; i_wdata = 8'h7F; i_set_sticky = 1'b1;
    step(); i_init = 1'b0; i_ld = 1'b0; i_set_sticky = 1'b0; i_wdata = 8'h00;
    repeat (23) step();

    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL unchecked_expectations left=%0d", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
